// File: rtl/hazard_fwd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl_pkg
// Shared types and constants for the hazard / forwarding controller.
//   REG_AW        register-number width (32 architectural registers)
//   FWD_*         operand source-select encodings driven on fwda / fwdb
//   stage_ctrl_t  destination/control fields carried by a shadow stage
//   live_match()  "this stage writes a real register that the reader names"
// ---------------------------------------------------------------------------
package hazard_fwd_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF   = 2'd0;  // register file
  localparam logic [1:0] FWD_EALU = 2'd1;  // E-stage ALU result
  localparam logic [1:0] FWD_MALU = 2'd2;  // M-stage ALU result
  localparam logic [1:0] FWD_MMEM = 2'd3;  // M-stage load data

  typedef logic [REG_AW-1:0] reg_num_t;

  typedef struct packed {
    logic     wreg;
    logic     m2reg;
    logic     aluimm;
    reg_num_t rn;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_BUBBLE = '{
    wreg:   1'b0,
    m2reg:  1'b0,
    aluimm: 1'b0,
    rn:     {REG_AW{1'b0}}
  };

  // Register 0 is hard-wired zero, so a "write" to it never creates a hazard.
  function automatic logic live_match(input logic wr, input reg_num_t dst,
                                      input reg_num_t src);
    return wr & (dst != {REG_AW{1'b0}}) & (dst == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl_if
// Bundle between the pipeline datapath and the hazard/forwarding controller.
//   ID side  : d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_rn, d_wreg,
//              d_m2reg, d_aluimm, flush, cnt_clr
//   Ctrl side: stall, fwda, fwdb, ealuimm, ewreg, ern, mwreg, mrn, mm2reg,
//              stall_cnt
// modport master : datapath view (drives ID side, reads controller outputs)
// modport slave  : controller view
// ---------------------------------------------------------------------------
interface hazard_fwd_ctrl_if
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic             d_valid;
  reg_num_t         d_rs;
  reg_num_t         d_rt;
  logic             d_use_rs;
  logic             d_use_rt;
  reg_num_t         d_rn;
  logic             d_wreg;
  logic             d_m2reg;
  logic             d_aluimm;
  logic             flush;
  logic             cnt_clr;

  logic             stall;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             ealuimm;
  logic             ewreg;
  reg_num_t         ern;
  logic             mwreg;
  reg_num_t         mrn;
  logic             mm2reg;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_rn,
           d_wreg, d_m2reg, d_aluimm, flush, cnt_clr,
    input  stall, fwda, fwdb, ealuimm, ewreg, ern,
           mwreg, mrn, mm2reg, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_rn,
           d_wreg, d_m2reg, d_aluimm, flush, cnt_clr,
    output stall, fwda, fwdb, ealuimm, ewreg, ern,
           mwreg, mrn, mm2reg, stall_cnt
  );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Purely combinational source-select for one ID-stage operand.
//   use_i              operand is read by a valid ID instruction
//   src_i              operand register number
//   ewreg_i/em2reg_i/ern_i   E-stage shadow
//   mwreg_i/mm2reg_i/mrn_i   M-stage shadow
//   sel_o              FWD_RF / FWD_EALU / FWD_MALU / FWD_MMEM
// ---------------------------------------------------------------------------
module fwd_sel
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic       use_i,
  input  reg_num_t   src_i,
  input  logic       ewreg_i,
  input  logic       em2reg_i,
  input  reg_num_t   ern_i,
  input  logic       mwreg_i,
  input  logic       mm2reg_i,
  input  reg_num_t   mrn_i,
  output logic [1:0] sel_o
);

  // Youngest producer wins. An E-stage load is skipped here: its data is not
  // ready yet and the stall logic holds the consumer instead.
  always_comb begin
    sel_o = FWD_RF;
    if (!use_i || (src_i == {REG_AW{1'b0}})) begin
      sel_o = FWD_RF;
    end else if (ewreg_i && !em2reg_i && (ern_i == src_i)) begin
      sel_o = FWD_EALU;
    end else if (mwreg_i && (mrn_i == src_i)) begin
      sel_o = mm2reg_i ? FWD_MMEM : FWD_MALU;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard and forwarding controller for the 5-stage pipeline. Shadows the
// E- and M-stage destination/control fields, derives forwarding selects and
// the load-use stall for the ID instruction, and counts stall cycles.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : hazard_fwd_ctrl_if.slave (ID inputs, flush, cnt_clr; stall,
//          fwda/fwdb, E/M shadow fields, stall_cnt)
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_ctrl_if.slave bus
);

  stage_ctrl_t      e_q, e_d;
  logic             mwreg_q;
  logic             mm2reg_q;
  reg_num_t         mrn_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             use_rs;
  logic             use_rt;
  logic             stall;
  logic             kill_id;

  // Operand reads only count for a real instruction in ID.
  always_comb begin
    use_rs = bus.d_use_rs & bus.d_valid;
    use_rt = bus.d_use_rt & bus.d_valid;
  end

  // Load-use hazard: the load in E cannot feed ID until it reaches M.
  always_comb begin
    stall = e_q.m2reg & (live_match(e_q.wreg, e_q.rn, bus.d_rs) & use_rs |
                         live_match(e_q.wreg, e_q.rn, bus.d_rt) & use_rt);
  end

  fwd_sel u_fwd_sel_rs (
    .use_i    (use_rs),
    .src_i    (bus.d_rs),
    .ewreg_i  (e_q.wreg),
    .em2reg_i (e_q.m2reg),
    .ern_i    (e_q.rn),
    .mwreg_i  (mwreg_q),
    .mm2reg_i (mm2reg_q),
    .mrn_i    (mrn_q),
    .sel_o    (bus.fwda)
  );

  fwd_sel u_fwd_sel_rt (
    .use_i    (use_rt),
    .src_i    (bus.d_rt),
    .ewreg_i  (e_q.wreg),
    .em2reg_i (e_q.m2reg),
    .ern_i    (e_q.rn),
    .mwreg_i  (mwreg_q),
    .mm2reg_i (mm2reg_q),
    .mrn_i    (mrn_q),
    .sel_o    (bus.fwdb)
  );

  // Next E-stage contents: a bubble whenever the ID instruction does not
  // advance (stalled, flushed, or empty); otherwise its qualified fields.
  always_comb begin
    kill_id = stall | bus.flush | ~bus.d_valid;
    e_d     = STAGE_BUBBLE;
    if (kill_id) begin
      e_d = STAGE_BUBBLE;
    end else begin
      e_d.wreg   = bus.d_wreg & bus.d_valid;
      e_d.m2reg  = bus.d_m2reg & bus.d_valid;
      e_d.aluimm = bus.d_aluimm;
      e_d.rn     = bus.d_rn;
    end
  end

  // Saturating stall counter; a clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Shadow pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q      <= STAGE_BUBBLE;
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mrn_q    <= {REG_AW{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      e_q      <= e_d;
      mwreg_q  <= e_q.wreg;
      mm2reg_q <= e_q.m2reg;
      mrn_q    <= e_q.rn;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.ealuimm   = e_q.aluimm;
  assign bus.ewreg     = e_q.wreg;
  assign bus.ern       = e_q.rn;
  assign bus.mwreg     = mwreg_q;
  assign bus.mrn       = mrn_q;
  assign bus.mm2reg    = mm2reg_q;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Directed scoreboard bench for hazard_fwd_ctrl. Each step drives the ID
// inputs at the falling edge, pushes the expected outputs, then pops and
// compares them 1 time unit later. The counter is built 8 bits wide so the
// saturation case is reached quickly.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  localparam int TB_CNT_W = 8;
  localparam logic [TB_CNT_W-1:0] CNT_SAT = {TB_CNT_W{1'b1}};

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hazard_fwd_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  hazard_fwd_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               tag;
    int                  kind;  // 0 comb outputs, 1 shadow regs + count, 2 count only
    logic                st;
    logic [1:0]          fa;
    logic [1:0]          fb;
    logic                ai;
    logic                ew;
    logic [4:0]          ern;
    logic                mw;
    logic [4:0]          mrn;
    logic                mm;
    logic [TB_CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic id_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rn,
                       input logic w, input logic m, input logic imm, input logic fl);
    bus.d_valid  = v;
    bus.d_rs     = rs;
    bus.d_rt     = rt;
    bus.d_use_rs = urs;
    bus.d_use_rt = urt;
    bus.d_rn     = rn;
    bus.d_wreg   = w;
    bus.d_m2reg  = m;
    bus.d_aluimm = imm;
    bus.flush    = fl;
  endtask

  task automatic exp_c(input string tag, input logic st, input logic [1:0] fa,
                       input logic [1:0] fb);
    exp_t e;
    e.tag = tag; e.kind = 0; e.st = st; e.fa = fa; e.fb = fb;
    sb.push_back(e);
  endtask

  task automatic exp_r(input string tag, input logic ai, input logic ew,
                       input logic [4:0] ern, input logic mw, input logic [4:0] mrn,
                       input logic mm, input logic [TB_CNT_W-1:0] cnt);
    exp_t e;
    e.tag = tag; e.kind = 1; e.ai = ai; e.ew = ew; e.ern = ern;
    e.mw = mw; e.mrn = mrn; e.mm = mm; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic exp_cnt(input string tag, input logic [TB_CNT_W-1:0] cnt);
    exp_t e;
    e.tag = tag; e.kind = 2; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic observe();
    #1;
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.kind == 0) begin
        chk({e.tag, "/stall"}, 32'(bus.stall), 32'(e.st));
        chk({e.tag, "/fwda"},  32'(bus.fwda),  32'(e.fa));
        chk({e.tag, "/fwdb"},  32'(bus.fwdb),  32'(e.fb));
      end else if (e.kind == 1) begin
        chk({e.tag, "/ealuimm"},   32'(bus.ealuimm),   32'(e.ai));
        chk({e.tag, "/ewreg"},     32'(bus.ewreg),     32'(e.ew));
        chk({e.tag, "/ern"},       32'(bus.ern),       32'(e.ern));
        chk({e.tag, "/mwreg"},     32'(bus.mwreg),     32'(e.mw));
        chk({e.tag, "/mrn"},       32'(bus.mrn),       32'(e.mrn));
        chk({e.tag, "/mm2reg"},    32'(bus.mm2reg),    32'(e.mm));
        chk({e.tag, "/stall_cnt"}, 32'(bus.stall_cnt), 32'(e.cnt));
      end else begin
        chk({e.tag, "/stall_cnt"}, 32'(bus.stall_cnt), 32'(e.cnt));
      end
    end
  endtask

  task automatic rand_id();
    id_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst         = 1'b1;
    bus.cnt_clr = 1'b0;
    rand_id();
    repeat (2) @(posedge clk);

    // Reset held with arbitrary ID traffic: shadows empty, everything reads 0.
    @(negedge clk); rand_id();
    exp_r("rst", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'd0);
    exp_c("rst", 1'b0, 2'd0, 2'd0);
    observe();

    // ALU back-to-back: add r3, then readers of r3 from E then from M.
    @(negedge clk); rst = 1'b0; id_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_r("alu0", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'd0);
    exp_c("alu0", 1'b0, 2'd0, 2'd0);
    observe();
    @(negedge clk); id_in(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_r("alu1", 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 8'd0);
    exp_c("alu1", 1'b0, 2'd1, 2'd0);
    observe();
    @(negedge clk); id_in(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_r("alu2", 1'b0, 1'b1, 5'd4, 1'b1, 5'd3, 1'b0, 8'd0);
    exp_c("alu2", 1'b0, 2'd2, 2'd1);
    observe();

    // Load-use: load r5, consumer reads rt=5 -> one stall, then fwdb = 3.
    @(negedge clk); id_in(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_r("ld", 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 8'd0);
    exp_c("ld", 1'b0, 2'd0, 2'd0);
    observe();
    @(negedge clk); id_in(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_r("lu_stall", 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 8'd0);
    exp_c("lu_stall", 1'b1, 2'd0, 2'd0);
    observe();
    @(negedge clk);
    exp_r("lu_after", 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 8'd1);
    exp_c("lu_after", 1'b0, 2'd0, 2'd3);
    observe();

    // Register 0: loads/writes to r0 never stall or forward.
    @(negedge clk); id_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_r("r0_a", 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 8'd1);
    exp_c("r0_a", 1'b0, 2'd0, 2'd0);
    observe();
    @(negedge clk); id_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_r("r0_b", 1'b0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 8'd1);
    exp_c("r0_b", 1'b0, 2'd0, 2'd0);
    observe();
    @(negedge clk); id_in(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_r("r0_c", 1'b0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 8'd1);
    exp_c("r0_c", 1'b0, 2'd1, 2'd0);
    observe();

    // Priority: E and M both write r7 -> E wins. This one captures aluimm.
    @(negedge clk); id_in(1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_r("prio", 1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 8'd1);
    exp_c("prio", 1'b0, 2'd1, 2'd0);
    observe();

    // aluimm visible one cycle later; this capture is flushed.
    @(negedge clk); id_in(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_r("imm_cap", 1'b1, 1'b0, 5'd9, 1'b1, 5'd7, 1'b0, 8'd1);
    exp_c("imm_cap", 1'b0, 2'd2, 2'd0);
    observe();
    @(negedge clk); id_in(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_r("flushed", 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 8'd1);
    exp_c("invalid", 1'b0, 2'd0, 2'd0);
    observe();

    // Stall and flush together still give a bubble and count the stall.
    @(negedge clk); id_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_r("inv_bub", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'd1);
    exp_c("ld12", 1'b0, 2'd0, 2'd0);
    observe();
    @(negedge clk); id_in(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_r("st_fl", 1'b0, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 8'd1);
    exp_c("st_fl", 1'b1, 2'd0, 2'd0);
    observe();
    @(negedge clk); id_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_r("st_fl_bub", 1'b0, 1'b0, 5'd0, 1'b1, 5'd12, 1'b1, 8'd2);
    exp_c("idle", 1'b0, 2'd0, 2'd0);
    observe();

    // Reset mid-operation forgets an in-flight load and its pending stall.
    @(negedge clk); id_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_c("ld14", 1'b0, 2'd0, 2'd0);
    observe();
    @(negedge clk); rst = 1'b1; id_in(1'b1, 5'd14, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_r("pre_rst", 1'b0, 1'b1, 5'd14, 1'b0, 5'd0, 1'b0, 8'd2);
    exp_c("pre_rst", 1'b1, 2'd0, 2'd0);
    observe();
    @(negedge clk); rst = 1'b0;
    exp_r("post_rst", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'd0);
    exp_c("post_rst", 1'b0, 2'd0, 2'd0);
    observe();

    // Counter saturation: one stall every two cycles, past all-ones.
    for (int i = 0; i < 259; i++) begin
      @(negedge clk); id_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_cnt("sat_cnt", (i > 255) ? CNT_SAT : TB_CNT_W'(i));
      observe();
      @(negedge clk); id_in(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_c("sat_stall", 1'b1, 2'd0, 2'd0);
      observe();
    end
    @(negedge clk); id_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("sat_final", CNT_SAT);
    observe();

    // Clear concurrent with a stall wins, then counting resumes from zero.
    @(negedge clk); bus.cnt_clr = 1'b1;
    id_in(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_c("clr_stall", 1'b1, 2'd0, 2'd0);
    exp_cnt("clr_pre", CNT_SAT);
    observe();
    @(negedge clk); bus.cnt_clr = 1'b0;
    id_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt("clr_post", 8'd0);
    observe();
    @(negedge clk); id_in(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_c("recount", 1'b1, 2'd0, 2'd0);
    observe();
    @(negedge clk); id_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_cnt("recount", 8'd1);
    observe();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage CPU.
- Keeps shadow E-stage and M-stage copies of each instruction's destination/control fields.
- Each cycle compares ID-stage source registers against those copies, then drives:
  - ID-stage forwarding selects fwda/fwdb;
  - the load-use stall;
  - the registered E-stage operand-B select ealuimm, which feeds the EX operand-B multiplexer.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_AW, 5, register-number width (32 architectural registers; register 0 is hard-wired zero).
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- d_valid  in  1  ID holds a real instruction
- d_rs  in  REG_AW  ID source register A
- d_rt  in  REG_AW  ID source register B
- d_use_rs  in  1  instruction reads rs
- d_use_rt  in  1  instruction reads rt
- d_rn  in  REG_AW  ID destination register
- d_wreg  in  1  ID instruction writes register file
- d_m2reg  in  1  ID instruction is a load
- d_aluimm  in  1  ID instruction uses immediate as ALU B
- flush  in  1  kill ID instruction (taken branch/jump)
- cnt_clr  in  1  clear stall counter
- stall  out  1  hold PC and IF/ID register; insert bubble into E
- fwda  out  2  rs source select: 0 regfile, 1 E ALU result, 2 M ALU result, 3 M load data
- fwdb  out  2  rt source select, same encoding
- ealuimm  out  1  E-stage operand-B select (0 register qb, 1 sign-extended immediate)
- ewreg  out  1  E-stage shadow write enable
- ern  out  REG_AW  E-stage shadow destination
- mwreg  out  1  M-stage shadow write enable
- mrn  out  REG_AW  M-stage shadow destination
- mm2reg  out  1  M-stage shadow load flag
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - E shadow (ewreg, em2reg, ealuimm, ern) = 0.
  - M shadow (mwreg, mm2reg, mrn) = 0.
  - stall_cnt = 0.
  - stall, fwda, fwdb are combinational and read 0 after reset, since the shadows are empty.
- Qualified ID flags: dw = d_wreg & d_valid; dm = d_m2reg & d_valid. The use_rs/use_rt terms below are likewise qualified by d_valid.
- Load-use stall, combinational:
  - stall = d_valid & ewreg & em2reg & (ern != 0) & ((d_use_rs & ern == d_rs) | (d_use_rt & ern == d_rt)).
- Forwarding, combinational, for the rs side (fwdb identical with d_rt / d_use_rt):
  - If not d_use_rs or d_rs == 0: select 0.
  - Else if ewreg & ~em2reg & ern == d_rs: select 1. The E stage has priority over the M stage.
  - Else if mwreg & mrn == d_rs: select 2 if ~mm2reg, else 3.
  - Else: select 0.
  - If E holds a matching load, stall is asserted and the fwda value is don't-care. It must still not be 1.
- Shadow pipeline, on each clk edge when rst = 0:
  - M <= E unconditionally: mwreg <= ewreg, mm2reg <= em2reg, mrn <= ern.
  - If stall | flush | ~d_valid: E <= bubble (all flags 0, ern = 0).
  - Else: E <= {dw, dm, d_aluimm, d_rn}.
  - flush and stall in the same cycle: bubble (same result either way).
- Latency:
  - ealuimm reflects the ID-stage d_aluimm exactly one cycle after capture.
  - A stall lasts exactly one cycle per load-use hazard. Next cycle E holds a bubble and the load is in M, so fwd = 3.
- stall_cnt:
  - rst or cnt_clr: 0. cnt_clr has priority over increment.
  - Else increment when stall = 1.
  - Saturates at all-ones; no wrap-around.
- Reset mid-operation:
  - Shadows are cleared, so any in-flight writer is forgotten.
  - stall deasserts in the cycle after reset.

Decomposition:
- Shared package holds:
  - fwd select constants FWD_RF = 0, FWD_EALU = 1, FWD_MALU = 2, FWD_MMEM = 3;
  - REG_AW;
  - a packed stage-control struct {wreg, m2reg, aluimm, rn}.
- One natural sub-module: fwd_sel, the pure combinational comparator for one source operand, instantiated twice (rs, rt). The shadow registers and counter stay in the top level.

Test Plan:
- Reset: rst = 1 for 2 cycles with random ID inputs -> all outputs 0; stall_cnt = 0.
- ALU back-to-back: add r3 (dw = 1, rn = 3), then an instruction with rs = 3 -> fwda = 1 in the second cycle; next instruction rs = 3 -> fwda = 2.
- Load-use: load r5 (dm = 1, dw = 1), then an instruction with rt = 5 and use_rt = 1 -> stall = 1 for exactly one cycle and E bubble; next cycle fwdb = 3, stall = 0; stall_cnt = 1.
- Register 0 and priority:
  - Writers target r0 -> fwda = fwdb = 0, no stall.
  - E and M both write r7, with E a non-load -> fwda = 1.
- Flush and ealuimm:
  - d_aluimm = 1 captured -> ealuimm = 1 the next cycle.
  - Same capture with flush = 1 -> ealuimm = 0 and ewreg = 0.
- Counter: force 2^16+3 stall cycles -> stall_cnt = 0xFFFF; cnt_clr concurrent with stall -> 0.
